// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared types and constants for the UART receive path.
// Contents : rx_state_t receiver state enum, parity mode codes,
//            oversampling constants.
// Revision : 1.0  initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4,
    BREAK = 3'd5
  } rx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 8;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/sync_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock first-word-fall-through FIFO, depth 2^AW.
// Ports    : clk, reset (sync, active-high)
//            wr/wdata  - push; accepted when not full, or full with rd
//            rd        - pop head; ignored while empty
//            rdata     - head entry (0 while empty)
//            count     - stored entries, AW+1 bits
//            full/empty- status
// Revision : 1.0  initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [2**AW];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      count_q, count_d;
  logic             do_wr, do_rd;

  // Count never exceeds 2^AW, so its MSB alone marks full.
  assign full  = count_q[AW];
  assign empty = (count_q == '0);
  assign count = count_q;

  // When full, wptr == rptr: a simultaneous write lands in the slot being
  // popped, which is safe because the head moves past it this cycle.
  assign do_wr = wr && (!full || rd);
  assign do_rd = rd && !empty;

  assign rdata = empty ? '0 : mem_q[rptr_q];

  always_comb begin
    count_d = count_q;
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_wr) wptr_q <= wptr_q + 1'b1;
      if (do_rd) rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wptr_q] <= wdata;
  end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Purpose  : 16x oversampled UART receiver with configurable data width and
//            parity, runtime baud divisor, FWFT receive FIFO and sticky
//            error flags.
// Ports    : clk, reset (sync, active-high)
//            baud_div   - oversample tick period minus 1 (clk cycles)
//            RX         - asynchronous serial input, idles high
//            rd         - pop head FIFO entry
//            rx_data    - head entry, valid while rx_valid
//            rx_valid   - FIFO not empty
//            fifo_count - stored entries
//            framing_err/parity_err/overrun - sticky flags
//            clr_err    - clear sticky flags (a same-cycle set wins)
// Revision : 1.0  initial release
// ============================================================================
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int DIV_W     = 16,
  parameter int FIFO_AW   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic                 RX,
  input  logic                 rd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic [FIFO_AW:0]     fifo_count,
  output logic                 framing_err,
  output logic                 parity_err,
  output logic                 overrun,
  input  logic                 clr_err
);

  logic                 rx_meta_q, rx_sync_q;
  logic [DIV_W-1:0]     presc_q;
  logic                 tick;
  rx_state_t            state_q, state_d;
  logic [3:0]           tcnt_q, tcnt_d;
  logic [2:0]           bitcnt_q, bitcnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 badpar_q, badpar_d;
  logic                 fe_q, pe_q, ov_q;
  logic                 set_fe, set_pe, push;
  logic                 mid_pt, bit_end, exp_par;
  logic                 fifo_full, fifo_empty;

  // >= rather than == so a divisor lowered below the running count still
  // produces a tick on the next cycle instead of waiting for wrap-around.
  assign tick    = (presc_q >= baud_div);
  assign mid_pt  = tick && (tcnt_q == 4'(MID_SAMPLE - 1));
  assign bit_end = tick && (tcnt_q == 4'(OVERSAMPLE - 1));
  // Parity bit that makes XOR(data, parity) = 1 (odd) or 0 (even).
  assign exp_par = (PARITY == PAR_ODD) ? ~^shreg_q : ^shreg_q;

  always_comb begin
    state_d  = state_q;
    tcnt_d   = tcnt_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    badpar_d = badpar_q;
    set_fe   = 1'b0;
    set_pe   = 1'b0;
    push     = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick && !rx_sync_q) begin
          tcnt_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (mid_pt) begin
          tcnt_d = '0;
          if (rx_sync_q) begin
            state_d = IDLE;
          end else begin
            state_d  = DATA;
            bitcnt_d = '0;
            badpar_d = 1'b0;
          end
        end else if (tick) begin
          tcnt_d = tcnt_q + 4'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          tcnt_d  = '0;
          shreg_d = {rx_sync_q, shreg_q[DATA_BITS-1:1]};
          if (bitcnt_q == 3'(DATA_BITS - 1)) begin
            state_d = (PARITY != PAR_NONE) ? PAR : STOP;
          end else begin
            bitcnt_d = bitcnt_q + 3'd1;
          end
        end else if (tick) begin
          tcnt_d = tcnt_q + 4'd1;
        end
      end
      PAR: begin
        if (bit_end) begin
          tcnt_d   = '0;
          badpar_d = (rx_sync_q != exp_par);
          state_d  = STOP;
        end else if (tick) begin
          tcnt_d = tcnt_q + 4'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          tcnt_d = '0;
          if (!rx_sync_q) begin
            set_fe  = 1'b1;
            state_d = BREAK;
          end else if (badpar_q) begin
            set_pe  = 1'b1;
            state_d = IDLE;
          end else begin
            push    = 1'b1;
            state_d = IDLE;
          end
        end else if (tick) begin
          tcnt_d = tcnt_q + 4'd1;
        end
      end
      BREAK: begin
        // Held-low line: stay here so it yields a single framing error.
        if (rx_sync_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      presc_q   <= '0;
      state_q   <= IDLE;
      tcnt_q    <= '0;
      bitcnt_q  <= '0;
      shreg_q   <= '0;
      badpar_q  <= 1'b0;
      fe_q      <= 1'b0;
      pe_q      <= 1'b0;
      ov_q      <= 1'b0;
    end else begin
      rx_meta_q <= RX;
      rx_sync_q <= rx_meta_q;
      presc_q   <= tick ? '0 : presc_q + DIV_W'(1);
      state_q   <= state_d;
      tcnt_q    <= tcnt_d;
      bitcnt_q  <= bitcnt_d;
      shreg_q   <= shreg_d;
      badpar_q  <= badpar_d;
      fe_q      <= set_fe | (fe_q & ~clr_err);
      pe_q      <= set_pe | (pe_q & ~clr_err);
      ov_q      <= (push & fifo_full & ~rd) | (ov_q & ~clr_err);
    end
  end

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .wr    (push),
    .wdata (shreg_q),
    .rd    (rd),
    .rdata (rx_data),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign rx_valid    = !fifo_empty;
  assign framing_err = fe_q;
  assign parity_err  = pe_q;
  assign overrun     = ov_q;

endmodule : uart_rx_fifo
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_fifo
// Purpose  : Self-checking bench for uart_rx_fifo. Instance A is 8N1,
//            instance B is 8E1. Expected FIFO contents and flags come from
//            a frame-level queue model.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx_fifo;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] baud_div = 16'd1;
  logic        rx_a = 1'b1, rx_b = 1'b1;
  logic        rd_a = 1'b0, rd_b = 1'b0;
  logic        clr_err = 1'b0;

  logic [7:0]  data_a, data_b;
  logic        valid_a, valid_b;
  logic [4:0]  cnt_a, cnt_b;
  logic        fe_a, fe_b, pe_a, pe_b, ov_a, ov_b;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  bit [1:0]   fe_m, pe_m, ov_m;

  always #5 clk = ~clk;

  uart_rx_fifo #(.DATA_BITS(8), .PARITY(0), .DIV_W(16), .FIFO_AW(4)) dut_a (
    .clk(clk), .reset(reset), .baud_div(baud_div), .RX(rx_a), .rd(rd_a),
    .rx_data(data_a), .rx_valid(valid_a), .fifo_count(cnt_a),
    .framing_err(fe_a), .parity_err(pe_a), .overrun(ov_a), .clr_err(clr_err)
  );

  uart_rx_fifo #(.DATA_BITS(8), .PARITY(2), .DIV_W(16), .FIFO_AW(4)) dut_b (
    .clk(clk), .reset(reset), .baud_div(baud_div), .RX(rx_b), .rd(rd_b),
    .rx_data(data_b), .rx_valid(valid_b), .fifo_count(cnt_b),
    .framing_err(fe_b), .parity_err(pe_b), .overrun(ov_b), .clr_err(clr_err)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int bit_time();
    return 16 * (int'(baud_div) + 1);
  endfunction

  task automatic drive_bit(input int which, input logic b);
    if (which == 0) rx_a = b; else rx_b = b;
    step(bit_time());
  endtask

  task automatic check_state(input int which);
    if (which == 0) begin
      check("cnt_a", cnt_a, qa.size());
      check("valid_a", valid_a, qa.size() != 0);
      if (qa.size() != 0) check("data_a", data_a, qa[0]);
      check("fe_a", fe_a, fe_m[0]);
      check("pe_a", pe_a, pe_m[0]);
      check("ov_a", ov_a, ov_m[0]);
    end else begin
      check("cnt_b", cnt_b, qb.size());
      check("valid_b", valid_b, qb.size() != 0);
      if (qb.size() != 0) check("data_b", data_b, qb[0]);
      check("fe_b", fe_b, fe_m[1]);
      check("pe_b", pe_b, pe_m[1]);
      check("ov_b", ov_b, ov_m[1]);
    end
  endtask

  // Full frame followed by one idle bit; a bad stop bit is followed by one
  // extra low bit before the line returns high.
  task automatic frame(input int which, input logic [7:0] d, input bit bad_par, input bit stop_ok);
    drive_bit(which, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(which, d[i]);
    if (which == 1) drive_bit(which, (^d) ^ bad_par);
    drive_bit(which, stop_ok);
    if (!stop_ok) drive_bit(which, 1'b0);
    drive_bit(which, 1'b1);
    if (!stop_ok) fe_m[which] = 1'b1;
    else if (which == 1 && bad_par) pe_m[which] = 1'b1;
    else if (which == 0) begin
      if (qa.size() == 16) ov_m[0] = 1'b1; else qa.push_back(d);
    end else begin
      if (qb.size() == 16) ov_m[1] = 1'b1; else qb.push_back(d);
    end
  endtask

  task automatic pop(input int which);
    if (which == 0) rd_a = 1'b1; else rd_b = 1'b1;
    step(1);
    rd_a = 1'b0;
    rd_b = 1'b0;
    if (which == 0 && qa.size() != 0) void'(qa.pop_front());
    if (which == 1 && qb.size() != 0) void'(qb.pop_front());
    check_state(which);
  endtask

  task automatic do_clr();
    clr_err = 1'b1;
    step(1);
    clr_err = 1'b0;
    fe_m = '0;
    pe_m = '0;
    ov_m = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    qa.delete();
    qb.delete();
    fe_m = '0;
    pe_m = '0;
    ov_m = '0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    int which, r, nrd;

    step(3);
    do_reset();
    // Reset state.
    check("rst_data_a", data_a, 8'h00);
    check_state(0);
    check_state(1);

    // 0x55 8N1, then read it back.
    frame(0, 8'h55, 1'b0, 1'b1);
    check_state(0);
    check("t1_data", data_a, 8'h55);
    pop(0);

    // Short low glitch: no frame, no flags.
    rx_a = 1'b0;
    step(8);
    rx_a = 1'b1;
    step(64);
    check_state(0);

    // 0xA3 with low stop bit, line held low: exactly one framing error.
    d = 8'hA3;
    drive_bit(0, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(0, d[i]);
    drive_bit(0, 1'b0);
    fe_m[0] = 1'b1;
    check_state(0);
    do_clr();
    step(3 * bit_time());
    check("t3_fe_once", fe_a, 1'b0);
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b1);
    check_state(0);

    // Even parity: 0x03 with parity 1 is bad, with parity 0 is good.
    frame(1, 8'h03, 1'b1, 1'b1);
    check_state(1);
    check("t4_pe", pe_b, 1'b1);
    frame(1, 8'h03, 1'b0, 1'b1);
    check_state(1);
    pop(1);
    do_clr();

    // Overrun: 17 bytes into a 16-deep FIFO.
    for (int i = 0; i <= 16; i++) frame(0, 8'(i), 1'b0, 1'b1);
    check_state(0);
    check("t5_cnt", cnt_a, 5'd16);
    check("t5_ov", ov_a, 1'b1);
    for (int i = 0; i < 16; i++) begin
      check("t5_order", data_a, 8'(i));
      pop(0);
    end
    do_clr();

    // Reset during data bit 4, then a clean 0x7E.
    d = 8'h7E;
    drive_bit(0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(0, d[i]);
    rx_a = d[4];
    step(bit_time() / 2);
    do_reset();
    check_state(0);
    rx_a = 1'b1;
    step(2 * bit_time());
    frame(0, 8'h7E, 1'b0, 1'b1);
    check_state(0);
    check("t6_data", data_a, 8'h7E);
    pop(0);

    // Randomized frames over both instances and several divisors.
    for (int k = 0; k < 24; k++) begin
      baud_div = 16'($urandom_range(0, 3));
      step(4);
      which = $urandom_range(0, 1);
      d = 8'($urandom);
      r = $urandom_range(0, 9);
      frame(which, d, r == 1, r != 0);
      check_state(which);
      nrd = $urandom_range(0, 2);
      for (int j = 0; j < nrd; j++) pop(which);
      if ($urandom_range(0, 4) == 0) begin
        do_clr();
        check_state(0);
        check_state(1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_uart_rx_fifo
`default_nettype wire

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised serial receive front end for the 6502 SoC's `RX` pin. It replaces the fixed 8N1 receiver with one that has:

- configurable data width and parity;
- a runtime baud divisor;
- 16× oversampling with start-bit validation;
- a first-word-fall-through receive FIFO;
- sticky framing, parity and overrun flags readable by the CPU bus glue.

## Interface

**Parameters**

- `DATA_BITS`, default 8: data bits per frame, legal 5..8.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even.
- `DIV_W`, default 16: width of the baud divisor.
- `FIFO_AW`, default 4: FIFO address width; depth = 2^FIFO_AW.

**Ports**

- `clk` in 1: system clock; all logic is on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `baud_div` in DIV_W: oversample tick period minus 1, in clk cycles; sampled every cycle.
- `RX` in 1: asynchronous serial input; idles high.
- `rd` in 1: pop the head entry of the FIFO.
- `rx_data` out DATA_BITS: head FIFO entry; valid while `rx_valid`=1.
- `rx_valid` out 1: FIFO not empty.
- `fifo_count` out FIFO_AW+1: number of stored entries.
- `framing_err` out 1: sticky; set when a stop bit is sampled low.
- `parity_err` out 1: sticky; set on parity mismatch.
- `overrun` out 1: sticky; set when a good byte arrives while the FIFO is full.
- `clr_err` in 1: clears all three sticky flags.

## Operation

**Input synchronisation**

- `RX` passes through a 2-FF synchroniser; both flops reset to 1.

**Prescaler**

- Free-running counter 0..`baud_div`.
- `tick` is a one-clk pulse when the count equals `baud_div`, then the count returns to 0.
- `baud_div`=0 gives a tick every clk.

**State machine** (`IDLE`, `START`, `DATA`, `PAR`, `STOP`, `BREAK`)

- `IDLE`: when a tick sees synchronised rx=0, clear the tick counter and go to `START`.
- `START`: after 8 ticks (mid-bit), re-sample.
  - rx=1 means a glitch: return to `IDLE`, no flags set.
  - rx=0: go to `DATA`.
- `DATA`: sample every 16 ticks.
  - Shift in LSB first into bit DATA_BITS-1, shifting right.
  - After DATA_BITS samples, go to `PAR` if PARITY≠0, else `STOP`.
- `PAR`: sample after 16 ticks.
  - The expected value makes the XOR of the data bits and the parity bit equal 1 for odd parity and 0 for even parity.
  - A mismatch latches an internal bad-parity bit.
- `STOP`: sample after 16 ticks.
  - rx=0: set `framing_err`, discard the byte, go to `BREAK`.
  - rx=1 and bad parity: set `parity_err`, discard the byte, go to `IDLE`.
  - rx=1 and good parity: write the byte to the FIFO, go to `IDLE`.
- `BREAK`: wait for synchronised rx=1, then go to `IDLE`. A held-low line produces exactly one framing error.

**FIFO write and read**

- Write when the FIFO is not full, or when it is full and `rd`=1 in the same cycle. In the full-with-`rd` case `fifo_count` is unchanged.
- A write while the FIFO is full and `rd`=0 is dropped and sets `overrun`. Stored data is untouched.
- `rd` while empty is ignored; the count never underflows.
- Pointers wrap modulo 2^FIFO_AW. The count is a separate FIFO_AW+1-bit register, so full = count equal to 2^FIFO_AW.

**Sticky flags**

- Setting a flag takes priority over `clr_err` in the same cycle.

## Timing

**Reset values**

- `rx_valid`=0, `fifo_count`=0, all flags 0.
- `rx_data`=0 (RAM output is don't-care while `rx_valid`=0).
- State is `IDLE`, prescaler is 0, synchroniser is 1s.

**Latencies**

- `RX` edge to FSM visibility: 2 clk (synchroniser), plus up to one tick period of phase jitter from the free-running prescaler.
- Stop-bit sample to `rx_valid`/`fifo_count` update: 1 clk.
- `rx_data` (first-word fall-through):
  - Holds the oldest entry combinationally from registered RAM state.
  - Advances the cycle after `rd`.
  - On the first write into an empty FIFO, valid the same cycle `rx_valid` rises.

**Reset mid-frame**

- The partial frame is discarded and the FIFO is emptied.
- The FSM re-arms on the next falling edge seen after the line has been high.

**Baud divisor change**

- A change of `baud_div` mid-frame takes effect at the next tick boundary; no other protection is provided.

## Structure

**Package `uart_pkg`**

- State enum `rx_state_t`.
- Parity localparams `PAR_NONE`, `PAR_ODD`, `PAR_EVEN`.
- `OVERSAMPLE`=16 and `MID_SAMPLE`=8.

**Sub-module `sync_fifo`**

- Parameters: WIDTH, AW.
- Ports: `clk`, `reset`, `wr`, `wdata`, `rd`, `rdata`, `count`, `full`, `empty`.
- Reused later by the transmit path.

## Test plan

All scenarios use `baud_div`=1 (2 clk per tick, 32 clk per bit) unless stated.

1. Send 0x55 as 8N1 → after the stop bit, `rx_valid`=1, `rx_data`=0x55, `fifo_count`=1. Pulse `rd` → count 0, `rx_valid`=0.
2. Low glitch on `RX` lasting 4 ticks (8 clk) → FSM returns to `IDLE`, count 0, no flags set.
3. Frame 0xA3 with the stop bit driven low, then the line held low for 3 bit times → `framing_err`=1 exactly once, count 0. `clr_err` → flag 0.
4. PARITY=2, send 0x03 with parity bit 1 → `parity_err`=1, byte dropped. Same byte with parity bit 0 → `rx_data`=0x03.
5. FIFO_AW=4: send bytes 0x00..0x10 (17 bytes) without reading → `fifo_count`=16, `overrun`=1, and 16 reads return 0x00..0x0F in order.
6. Assert `reset` during data bit 4 of a frame, then send 0x7E → count 0 immediately after reset, then a single entry 0x7E with no flags set.
